uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, mid-bit sampling) feeding a byte FIFO behind a small
// register port: RXDATA (pop on read), STATUS (sticky error flags), CTRL.
module uart_rx_fifo #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned CLK_FREQ   = 10000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [3:0]      ADDRESS,
    input  logic [BITS-1:0] DATA_IN,
    output logic [BITS-1:0] DATA_OUT,
    input  logic            WR,
    input  logic            RD,
    input  logic            uart_rx,
    output logic            irq
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV + 1);
    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW   = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_s1_q, rx_s2_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            ovr_q, ovr_d, ferr_q, ferr_d;
    logic            en_q, en_d, ien_q, ien_d;
    logic            irq_q, irq_d;

    logic            cnt_exp_c, push_c, ferr_set_c;
    logic            pop_c, full_c, do_push_c, ovr_set_c, flush_c;
    logic            ctrl_wr_c, stat_wr_c;
    logic [15:0]     rdata_c;
    logic            unused_c;

    assign unused_c  = ^DATA_IN;
    assign cnt_exp_c = (cnt_q <= CW'(1));

    // Register-port decode
    assign ctrl_wr_c = WR && (ADDRESS == 4'h2);
    assign stat_wr_c = WR && (ADDRESS == 4'h1);
    assign flush_c   = ctrl_wr_c && DATA_IN[2];
    assign en_d      = ctrl_wr_c ? DATA_IN[0] : en_q;
    assign ien_d     = ctrl_wr_c ? DATA_IN[1] : ien_q;

    // Receiver next state; a same-cycle EN clear aborts any frame in progress
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s2_q) begin
                    state_d = ST_START;
                    cnt_d   = CW'(HALF);
                end
            end
            ST_START: begin
                if (cnt_exp_c) begin
                    if (!rx_s2_q) begin
                        state_d = ST_DATA;
                        cnt_d   = CW'(DIV);
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_exp_c) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = CW'(DIV);
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_exp_c) begin
                    if (rx_s2_q) begin
                        push_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en_d) begin
            state_d    = ST_IDLE;
            push_c     = 1'b0;
            ferr_set_c = 1'b0;
        end
    end

    assign pop_c     = RD && (ADDRESS == 4'h0) && (count_q != '0);
    assign full_c    = (count_q == NW'(FIFO_DEPTH));
    assign do_push_c = push_c && (!full_c || pop_c);
    assign ovr_set_c = push_c && full_c && !pop_c;

    // FIFO pointers and occupancy; flush overrides any push/pop
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_c) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push_c) wptr_d = wptr_q + AW'(1);
            if (pop_c)     rptr_d = rptr_q + AW'(1);
            if (do_push_c && !pop_c)      count_d = count_q + NW'(1);
            else if (!do_push_c && pop_c) count_d = count_q - NW'(1);
        end
    end

    // Set beats clear for the sticky flags
    assign ovr_d  = ovr_set_c  ? 1'b1 : ((stat_wr_c && DATA_IN[2]) ? 1'b0 : ovr_q);
    assign ferr_d = ferr_set_c ? 1'b1 : ((stat_wr_c && DATA_IN[3]) ? 1'b0 : ferr_q);
    assign irq_d  = ien_q && ((count_q != '0) || ovr_q || ferr_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            en_q    <= 1'b0;
            ien_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            en_q    <= en_d;
            ien_q   <= ien_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push_c) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    // Register read mux
    always_comb begin
        rdata_c = '0;
        unique case (ADDRESS)
            4'h0: if (count_q != '0) rdata_c = {8'h80, mem_q[rptr_q]};
            4'h1: rdata_c = {3'b000, 5'(count_q), 4'b0000,
                             ferr_q, ovr_q, full_c, (count_q != '0)};
            4'h2: rdata_c = {14'd0, ien_q, en_q};
            default: rdata_c = '0;
        endcase
    end

    assign DATA_OUT = BITS'(rdata_c);
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit-by-bit, registers checked
// against a queue-based model of the FIFO and its sticky flags.
module tb_uart_rx_fifo;

    localparam int DIV   = 10000000 / 115200;
    localparam int DEPTH = 16;

    logic        CLK;
    logic        RST;
    logic [3:0]  ADDRESS;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;
    logic        WR;
    logic        RD;
    logic        uart_rx;
    logic        irq;

    int          n_cmp;
    int          n_bad;
    int          push_iter;
    int          lat_iter;
    logic [7:0]  mq[$];
    logic        m_ovr, m_ferr, m_en, m_ien;

    uart_rx_fifo #(
        .BITS       (16),
        .CLK_FREQ   (10000000),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .WR       (WR),
        .RD       (RD),
        .uart_rx  (uart_rx),
        .irq      (irq)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic logic [15:0] m_status();
        return {3'b000, 5'(mq.size()), 4'b0000, m_ferr, m_ovr,
                mq.size() == DEPTH, mq.size() != 0};
    endfunction

    function automatic logic [15:0] m_rxdata();
        if (mq.size() > 0) return {8'h80, mq[0]};
        return 16'h0000;
    endfunction

    function automatic logic [15:0] m_ctrl();
        return {14'd0, m_ien, m_en};
    endfunction

    function automatic logic [15:0] m_irq();
        return 16'(m_ien && (mq.size() > 0 || m_ovr || m_ferr));
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(b);
    endtask

    task automatic m_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_en   = 1'b0;
        m_ien  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [3:0] addr, output logic [15:0] val);
        ADDRESS = addr;
        RD      = 1'b0;
        WR      = 1'b0;
        #1;
        val = DATA_OUT;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        ADDRESS = addr;
        DATA_IN = data;
        WR      = 1'b1;
        RD      = 1'b0;
        tick();
        WR      = 1'b0;
        DATA_IN = '0;
        ADDRESS = 4'h1;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        logic [15:0] v;
        rd(addr, v);
        check(tag, v, exp);
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] v;
        ADDRESS = 4'h0;
        RD      = 1'b1;
        WR      = 1'b0;
        #1;
        v = DATA_OUT;
        check(tag, v, m_rxdata());
        tick();
        RD      = 1'b0;
        ADDRESS = 4'h1;
        if (mq.size() > 0) mq.delete(0);
    endtask

    // One 8N1 frame, one loop iteration per clock; optional pop, EN toggle
    // and reset injected at given iterations (-1 = none).
    task automatic frame(input logic [7:0] b, input logic stop_ok,
                         input int pop_at, input int dis_at, input int rst_at);
        logic [4:0]  cnt0;
        logic [15:0] v;
        int          k;
        push_iter = -1;
        ADDRESS = 4'h1; RD = 1'b0; WR = 1'b0; DATA_IN = '0;
        #1;
        cnt0 = DATA_OUT[12:8];
        for (int c = 0; c < 10 * DIV; c++) begin
            k = c / DIV;
            if (k == 0)      uart_rx = 1'b0;
            else if (k <= 8) uart_rx = b[k-1];
            else             uart_rx = stop_ok;
            ADDRESS = 4'h1; RD = 1'b0; WR = 1'b0; DATA_IN = '0;
            if (c == pop_at) begin
                ADDRESS = 4'h0;
                RD      = 1'b1;
                #1;
                v = DATA_OUT;
                check("pop_same_cycle", v, m_rxdata());
                if (mq.size() > 0) mq.delete(0);
            end
            if (dis_at >= 0 && c == dis_at) begin
                ADDRESS = 4'h2; WR = 1'b1; DATA_IN = {14'd0, m_ien, 1'b0};
            end
            if (dis_at >= 0 && c == dis_at + 1) begin
                ADDRESS = 4'h2; WR = 1'b1; DATA_IN = {14'd0, m_ien, 1'b1};
            end
            if (rst_at >= 0 && c == rst_at) begin
                RST = 1'b1;
                m_reset();
            end
            if (rst_at >= 0 && c == rst_at + 2) begin
                chk_reg("rst_mid_rxdata", 4'h0, 16'h0000);
                chk_reg("rst_mid_status", 4'h1, 16'h0000);
                chk_reg("rst_mid_ctrl", 4'h2, 16'h0000);
                check("rst_mid_irq", 16'(irq), 16'h0000);
                ADDRESS = 4'h1;
            end
            if (rst_at >= 0 && c == rst_at + 3) RST = 1'b0;
            tick();
            if (push_iter < 0 && ADDRESS == 4'h1 && DATA_OUT[12:8] != cnt0) push_iter = c;
        end
        uart_rx = 1'b1; ADDRESS = 4'h1; RD = 1'b0; WR = 1'b0; DATA_IN = '0;
        repeat (6) tick();
    endtask

    initial begin
        logic [7:0]  rb;
        logic        ok;
        logic        r_ien;
        logic [15:0] d;

        n_cmp = 0; n_bad = 0; lat_iter = -1; push_iter = -1;
        RST = 1'b1; uart_rx = 1'b1; ADDRESS = 4'h0; DATA_IN = '0; WR = 1'b0; RD = 1'b0;
        m_reset();
        repeat (3) tick();
        chk_reg("reset_rxdata", 4'h0, 16'h0000);
        chk_reg("reset_status", 4'h1, 16'h0000);
        chk_reg("reset_ctrl", 4'h2, 16'h0000);
        check("reset_irq", 16'(irq), 16'h0000);
        RST = 1'b0;
        tick();

        wr(4'h2, 16'h0001);
        m_en = 1'b1;
        chk_reg("ctrl_en", 4'h2, m_ctrl());

        // Single byte, measure push latency
        frame(8'hA5, 1'b1, -1, -1, -1);
        m_push(8'hA5);
        lat_iter = push_iter;
        check("push_in_stop_bit", 16'(push_iter >= 9 * DIV && push_iter < 10 * DIV), 16'h0001);
        chk_reg("a5_status", 4'h1, m_status());
        chk_reg("a5_rxdata", 4'h0, m_rxdata());
        pop_chk("a5_pop");
        chk_reg("a5_status_after_pop", 4'h1, m_status());
        chk_reg("other_addr", 4'h7, 16'h0000);

        // Overflow with 17 bytes
        for (int i = 0; i < 17; i++) begin
            frame(8'(i), 1'b1, -1, -1, -1);
            m_push(8'(i));
        end
        chk_reg("full_ovr_status", 4'h1, m_status());
        chk_reg("full_head", 4'h0, m_rxdata());
        wr(4'h1, 16'h0004);
        m_ovr = 1'b0;
        chk_reg("ovr_cleared", 4'h1, m_status());

        // Full FIFO: pop in the same cycle as the stop-bit push
        frame(8'h11, 1'b1, lat_iter, -1, -1);
        m_push(8'h11);
        chk_reg("full_pop_push_status", 4'h1, m_status());
        for (int i = 0; i < DEPTH; i++) pop_chk("drain_order");
        chk_reg("drained_status", 4'h1, m_status());

        // Framing error
        frame(8'h3C, 1'b0, -1, -1, -1);
        m_ferr = 1'b1;
        chk_reg("ferr_status", 4'h1, m_status());
        wr(4'h1, 16'h0008);
        m_ferr = 1'b0;
        chk_reg("ferr_cleared", 4'h1, m_status());

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        repeat (20) tick();
        uart_rx = 1'b1;
        repeat (3 * DIV) tick();
        chk_reg("glitch_status", 4'h1, m_status());
        frame(8'h5A, 1'b1, -1, -1, -1);
        m_push(8'h5A);
        chk_reg("after_glitch_rxdata", 4'h0, m_rxdata());
        pop_chk("after_glitch_pop");

        // EN cleared mid-frame, re-enabled while line is high
        frame(8'hE0, 1'b1, -1, 7 * DIV, -1);
        chk_reg("en_abort_status", 4'h1, m_status());

        // Randomized frames, pops and flag clears
        r_ien = 1'($urandom_range(0, 1));
        wr(4'h2, {14'd0, r_ien, 1'b1});
        m_ien = r_ien;
        for (int t = 0; t < 10; t++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            frame(rb, ok, -1, -1, -1);
            if (ok) m_push(rb);
            else m_ferr = 1'b1;
            chk_reg("rand_status", 4'h1, m_status());
            chk_reg("rand_rxdata", 4'h0, m_rxdata());
            check("rand_irq", 16'(irq), m_irq());
            if ($urandom_range(0, 1) == 1) pop_chk("rand_pop");
            if ($urandom_range(0, 3) == 0) begin
                d = 16'($urandom);
                wr(4'h1, d);
                if (d[2]) m_ovr = 1'b0;
                if (d[3]) m_ferr = 1'b0;
                chk_reg("rand_clear", 4'h1, m_status());
            end
        end
        frame(8'h77, 1'b1, -1, -1, -1);
        m_push(8'h77);
        wr(4'h2, {13'd0, 1'b1, m_ien, 1'b1});
        mq.delete();
        chk_reg("flush_status", 4'h1, m_status());
        chk_reg("flush_ctrl", 4'h2, m_ctrl());

        // Interrupt behaviour and reset mid-frame
        wr(4'h2, 16'h0003);
        m_en = 1'b1; m_ien = 1'b1;
        wr(4'h1, 16'h000C);
        m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (2) tick();
        check("irq_idle", 16'(irq), m_irq());
        rb = 8'($urandom);
        frame(rb, 1'b1, -1, -1, -1);
        m_push(rb);
        check("irq_on_byte", 16'(irq), m_irq());
        pop_chk("irq_pop");
        check("irq_lag", 16'(irq), 16'h0001);
        tick();
        check("irq_cleared", 16'(irq), m_irq());
        frame(8'h96, 1'b1, -1, -1, 4 * DIV);
        chk_reg("post_rst_status", 4'h1, m_status());
        chk_reg("post_rst_ctrl", 4'h2, m_ctrl());
        check("post_rst_irq", 16'(irq), m_irq());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
